// File: rtl/retry_end_limited.sv
// ---------------------------------------------------------------------------
// retry_end_limited
//
// Downstream end of a retry loop. It sits after the protected (pipelined)
// process and receives results tagged with an ID and a needs-retry flag.
//   - Good results, and failed results whose ID has used up its retry
//     budget, are forwarded downstream with zero latency. Exhausted
//     failures are marked with error_o.
//   - Other failed results have their ID captured in a one-entry holding
//     register. That register feeds the retry start stage one cycle later.
// A per-slot attempt counter bounds the number of retries per ID. The slot
// is the ID without its parity MSB.
//
// Optional feature (macro RETRY_END_STATS_EN):
//   When defined, this adds saturating statistics counters retry_count_o and
//   drop_count_o. When undefined, those ports and counters do not exist.
//
// Ports:
//   clk_i          clock
//   rst_ni         synchronous reset, active low
//   data_i         result from the process
//   id_i           ID travelling with the result (MSB is parity)
//   needs_retry_i  result is faulty, retry requested
//   valid_i        upstream valid
//   ready_o        upstream ready
//   data_o         result to the consumer
//   error_o        forwarded result is faulty (retries exhausted)
//   valid_o        downstream valid
//   ready_i        downstream ready
//   retry_id_o     ID to re-issue, to the retry start stage
//   retry_valid_o  retry request valid
//   retry_ready_i  retry start stage accepts the ID
//   retry_count_o  total retries issued            (RETRY_END_STATS_EN)
//   drop_count_o   total forced forwards with error (RETRY_END_STATS_EN)
// ---------------------------------------------------------------------------
module retry_end_limited #(
  parameter type DataType   = logic,
  parameter int  IDSize     = 2,
  parameter int  MaxRetries = 3,
  parameter int  StatWidth  = 16
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  DataType           data_i,
  input  logic [IDSize-1:0] id_i,
  input  logic              needs_retry_i,
  input  logic              valid_i,
  output logic              ready_o,
  output DataType           data_o,
  output logic              error_o,
  output logic              valid_o,
  input  logic              ready_i,
  output logic [IDSize-1:0] retry_id_o,
  output logic              retry_valid_o,
  input  logic              retry_ready_i
`ifdef RETRY_END_STATS_EN
  ,
  output logic [StatWidth-1:0] retry_count_o,
  output logic [StatWidth-1:0] drop_count_o
`endif
);

  localparam int NumSlots = 2 ** (IDSize - 1);
  localparam int SlotW    = IDSize - 1;
  // With MaxRetries = 0 the counter never leaves zero, but it still needs
  // one bit to exist.
  localparam int AttW     = (MaxRetries > 0) ? $clog2(MaxRetries + 1) : 1;
  localparam logic [AttW-1:0] AttMax = AttW'(MaxRetries);

  logic [SlotW-1:0]         slot;
  logic [NumSlots*AttW-1:0] attempts_flat;
  logic [AttW-1:0]          cur_attempts;
  logic                     exhausted;
  logic                     forward_path;
  logic                     fwd_hs;
  logic                     retry_hs;
  logic                     drain;

  logic [IDSize-1:0]        hold_id_reg;
  logic                     hold_valid_reg;

  assign slot         = id_i[IDSize-2:0];
  assign cur_attempts = attempts_flat[slot*AttW +: AttW];
  assign exhausted    = (cur_attempts == AttMax);
  assign forward_path = !needs_retry_i || exhausted;

  // The upstream ready comes only from the chosen path. On the retry path,
  // the holding register can take a new ID when it is empty or when it is
  // draining in this same cycle.
  always_comb begin
    ready_o = 1'b0;
    if (rst_ni) begin
      if (forward_path) ready_o = ready_i;
      else              ready_o = !hold_valid_reg || retry_ready_i;
    end
  end

  assign valid_o       = rst_ni && valid_i && forward_path;
  assign error_o       = valid_o && needs_retry_i;
  assign data_o        = data_i;
  assign retry_valid_o = rst_ni && hold_valid_reg;
  assign retry_id_o    = hold_id_reg;

  assign fwd_hs   = valid_i && ready_o && forward_path;
  assign retry_hs = valid_i && ready_o && !forward_path;
  assign drain    = hold_valid_reg && retry_ready_i;

  // One attempt counter per slot. Only the slot addressed by the current
  // handshake moves. A retry handshake implies !exhausted, so the increment
  // cannot pass MaxRetries.
  genvar gi;
  generate
    for (gi = 0; gi < NumSlots; gi++) begin : g_slot
      logic [AttW-1:0] attempts_reg;
      logic            hit;

      assign hit = (slot == SlotW'(gi));

      always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
          attempts_reg <= '0;
        end else if (fwd_hs && hit) begin
          attempts_reg <= '0;
        end else if (retry_hs && hit) begin
          attempts_reg <= attempts_reg + AttW'(1);
        end
      end

      assign attempts_flat[gi*AttW +: AttW] = attempts_reg;
    end
  endgenerate

  // Retry holding register. When a fill and a drain happen in the same
  // cycle, the new ID replaces the old one and valid stays high, so there
  // is no bubble.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      hold_id_reg    <= '0;
      hold_valid_reg <= 1'b0;
    end else if (retry_hs) begin
      hold_id_reg    <= id_i;
      hold_valid_reg <= 1'b1;
    end else if (drain) begin
      hold_valid_reg <= 1'b0;
    end
  end

`ifdef RETRY_END_STATS_EN
  logic [StatWidth-1:0] retry_count_reg;
  logic [StatWidth-1:0] drop_count_reg;

  // Both counters saturate at all-ones instead of wrapping.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      retry_count_reg <= '0;
      drop_count_reg  <= '0;
    end else begin
      if (retry_hs && (retry_count_reg != '1))
        retry_count_reg <= retry_count_reg + StatWidth'(1);
      if (fwd_hs && needs_retry_i && (drop_count_reg != '1))
        drop_count_reg <= drop_count_reg + StatWidth'(1);
    end
  end

  assign retry_count_o = retry_count_reg;
  assign drop_count_o  = drop_count_reg;
`endif

endmodule
